mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 147 ++++++++++++++
 tb/tb_mem_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Record-stream memory loader: parses HEADER/ADDR/LEN/DATA/CSUM records from a
// byte stream and issues one-cycle memory writes for each data byte.
module mem_loader #(
  parameter logic [7:0]  HEADER = 8'hA5,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       byte_count
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   remain_q, remain_d;
  logic [BYTE_W-1:0]   sum_q, sum_d;
  logic                len_zero_q, len_zero_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [BYTE_W-1:0]   mem_data_d;
  logic                mem_we_d;
  logic                busy_d;
  logic                done_d;
  logic                error_d;
  logic [CNT_W-1:0]    byte_count_d;
  logic [BYTE_W-1:0]   sum_add;

  assign sum_add = sum_q + rx_data;

  // State and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      addr_hi_q  <= '0;
      addr_q     <= '0;
      remain_q   <= '0;
      sum_q      <= '0;
      len_zero_q <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      byte_count <= '0;
    end else begin
      state_q    <= state_d;
      addr_hi_q  <= addr_hi_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      sum_q      <= sum_d;
      len_zero_q <= len_zero_d;
      mem_addr   <= mem_addr_d;
      mem_data   <= mem_data_d;
      mem_we     <= mem_we_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      byte_count <= byte_count_d;
    end
  end

  // Next-state and next-output logic; every transition is gated by rx_valid
  always_comb begin
    state_d      = state_q;
    addr_hi_d    = addr_hi_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    sum_d        = sum_q;
    len_zero_d   = len_zero_q;
    mem_addr_d   = mem_addr;
    mem_data_d   = mem_data;
    mem_we_d     = 1'b0;
    byte_count_d = byte_count;

    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == HEADER) begin
            state_d = S_ADDR_HI;
            sum_d   = '0;
          end
        end
        S_ADDR_HI: begin
          addr_hi_d = rx_data;
          sum_d     = sum_add;
          state_d   = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_d  = ADDR_W'({addr_hi_q, rx_data});
          sum_d   = sum_add;
          state_d = S_LEN;
        end
        S_LEN: begin
          sum_d      = sum_add;
          remain_d   = rx_data;
          len_zero_d = (rx_data == '0);
          state_d    = (rx_data == '0) ? S_CSUM : S_DATA;
        end
        S_DATA: begin
          sum_d        = sum_add;
          mem_we_d     = 1'b1;
          mem_addr_d   = addr_q;
          mem_data_d   = rx_data;
          addr_d       = addr_q + ADDR_W'(1);
          remain_d     = remain_q - BYTE_W'(1);
          byte_count_d = byte_count + CNT_W'(1);
          if (remain_q == BYTE_W'(1)) state_d = S_CSUM;
        end
        S_CSUM: begin
          sum_d = sum_add;
          if (sum_add != '0)   state_d = S_ERROR;
          else if (len_zero_q) state_d = S_DONE;
          else                 state_d = S_IDLE;
        end
        S_DONE, S_ERROR: ;
      endcase
    end

    // Status flags track the state being entered so they line up with it
    busy_d  = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed record scenarios plus randomized
// record streams checked against a record-level reference model.
module tb_mem_loader;

  localparam logic [7:0] HDR = 8'hA5;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] byte_count;

  mem_loader #(.HEADER(HDR), .ADDR_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .busy(busy), .done(done), .error(error), .byte_count(byte_count)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // Write entries: {cycle seen, address, data}
  logic [55:0] act_q[$];
  logic [55:0] exp_q[$];

  always @(negedge Clock)
    if (mem_we === 1'b1) act_q.push_back({32'(cyc), mem_addr, mem_data});

  // Reference model: collects the bytes of the current record and judges it by position
  logic [7:0]  rec[$];
  int          m_term;          // 0 running, 1 done, 2 error
  logic [15:0] m_cnt;

  int errors = 0;
  int checks = 0;

  task automatic model_reset();
    rec.delete();
    m_term = 0;
    m_cnt  = 16'h0;
  endtask

  task automatic model_step(input logic [7:0] b);
    int n;
    int len;
    logic [15:0] a;
    logic [7:0]  s;
    if (m_term != 0) return;
    if (rec.size() == 0) begin
      if (b == HDR) rec.push_back(b);
      return;
    end
    rec.push_back(b);
    n = rec.size();
    if (n < 5) return;
    len = int'(rec[3]);
    if (n <= 4 + len) begin
      a = {rec[1], rec[2]} + 16'(n - 5);
      exp_q.push_back({32'(cyc + 1), a, b});
      m_cnt = m_cnt + 16'd1;
    end else begin
      s = 8'h00;
      for (int i = 1; i < n; i++) s = s + rec[i];
      if (s != 8'h00)    m_term = 2;
      else if (len == 0) m_term = 1;
      rec.delete();
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge Clock);
    rx_data  = b;
    rx_valid = 1'b1;
    model_step(b);
  endtask

  task automatic idle();
    @(negedge Clock);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic settle();
    idle();
    idle();
    #1;
  endtask

  task automatic do_reset(input bit with_hdr);
    @(negedge Clock);
    Reset    = 1'b1;
    rx_valid = with_hdr;
    rx_data  = HDR;
    @(negedge Clock);
    Reset    = 1'b0;
    rx_valid = 1'b0;
    model_reset();
    act_q.delete();
    exp_q.delete();
    #1;
  endtask

  task automatic send_record(input logic [15:0] a, input int len, input bit good, input bit gaps);
    logic [7:0] bytes[$];
    logic [7:0] s;
    bytes.push_back(HDR);
    bytes.push_back(a[15:8]);
    bytes.push_back(a[7:0]);
    bytes.push_back(8'(len));
    for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
    s = 8'h00;
    for (int i = 1; i < bytes.size(); i++) s = s + bytes[i];
    if (good) bytes.push_back(8'(8'h00 - s));
    else      bytes.push_back(8'(8'h00 - s + 8'(1 + $urandom_range(0, 254))));
    foreach (bytes[i]) begin
      send(bytes[i]);
      if (gaps && $urandom_range(0, 2) == 0) idle();
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks++;
    if ({mem_addr, mem_data, mem_we, busy, done, error, byte_count} !== 44'h0) begin
      errors++;
      $display("FAIL reset_values: got addr=%h data=%h we=%b busy=%b done=%b err=%b cnt=%h expected all zero",
               mem_addr, mem_data, mem_we, busy, done, error, byte_count);
    end
    settle();
    checks++;
    if (busy !== 1'b0 || act_q.size() != 0) begin
      errors++;
      $display("FAIL reset_discard: got busy=%b writes=%0d expected busy=0 writes=0", busy, act_q.size());
    end
  endtask

  task automatic test_basic_and_done();
    logic [7:0] s1[] = '{8'hA5, 8'h00, 8'h10, 8'h02, 8'h12, 8'h34, 8'hA8,
                         8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    do_reset(1'b0);
    foreach (s1[i]) send(s1[i]);
    settle();
    checks++;
    if (act_q.size() != 2 || exp_q.size() != 2) begin
      errors++;
      $display("FAIL basic_wr_count: got %0d expected 2", act_q.size());
    end else begin
      foreach (act_q[i]) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL basic_wr[%0d]: got %h expected %h", i, act_q[i], exp_q[i]);
        end
      end
      checks++;
      if ({act_q[0][23:0], act_q[1][23:0]} !== 48'h001012_001134) begin
        errors++;
        $display("FAIL basic_wr_values: got %h %h expected 001012 001134", act_q[0][23:0], act_q[1][23:0]);
      end
    end
    checks++;
    if ({busy, done, error, byte_count} !== {3'b010, 16'd2}) begin
      errors++;
      $display("FAIL basic_status: got busy=%b done=%b err=%b cnt=%0d expected 0 1 0 2",
               busy, done, error, byte_count);
    end
    // Terminal DONE: a further valid record must be ignored
    act_q.delete();
    send_record(16'h0030, 1, 1'b1, 1'b0);
    settle();
    checks++;
    if (act_q.size() != 0 || done !== 1'b1 || byte_count !== 16'd2 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got writes=%0d done=%b cnt=%0d we=%b expected 0 1 2 0",
               act_q.size(), done, byte_count, mem_we);
    end
  endtask

  task automatic test_ignore_leading();
    logic [7:0] s2[] = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h10, 8'h01, 8'h55, 8'h9A};
    do_reset(1'b0);
    foreach (s2[i]) send(s2[i]);
    settle();
    checks++;
    if (act_q.size() != 1 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL ignore_wr_count: got %0d expected 1", act_q.size());
    end else begin
      checks++;
      if (act_q[0] !== exp_q[0] || act_q[0][23:0] !== 24'h001055) begin
        errors++;
        $display("FAIL ignore_wr: got %h expected %h", act_q[0], exp_q[0]);
      end
    end
    checks++;
    if ({busy, done, error, byte_count} !== {3'b000, 16'd1}) begin
      errors++;
      $display("FAIL ignore_status: got busy=%b done=%b err=%b cnt=%0d expected 0 0 0 1",
               busy, done, error, byte_count);
    end
  endtask

  task automatic test_wrap_error();
    logic [7:0] s3[] = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h00};
    do_reset(1'b0);
    foreach (s3[i]) send(s3[i]);
    settle();
    checks++;
    if (act_q.size() != 2 || exp_q.size() != 2) begin
      errors++;
      $display("FAIL wrap_wr_count: got %0d expected 2", act_q.size());
    end else begin
      checks++;
      if (act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1] ||
          {act_q[0][23:0], act_q[1][23:0]} !== 48'hFFFFAA_0000BB) begin
        errors++;
        $display("FAIL wrap_wr: got %h %h expected %h %h", act_q[0], act_q[1], exp_q[0], exp_q[1]);
      end
    end
    checks++;
    if ({busy, done, error} !== 3'b001) begin
      errors++;
      $display("FAIL wrap_status: got busy=%b done=%b err=%b expected 0 0 1", busy, done, error);
    end
    act_q.delete();
    send_record(16'h0001, 1, 1'b1, 1'b0);
    settle();
    checks++;
    if (act_q.size() != 0 || error !== 1'b1 || byte_count !== 16'd2) begin
      errors++;
      $display("FAIL error_terminal: got writes=%0d err=%b cnt=%0d expected 0 1 2",
               act_q.size(), error, byte_count);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] s4[] = '{8'hA5, 8'h00, 8'h40, 8'h04, 8'h11};
    do_reset(1'b0);
    foreach (s4[i]) send(s4[i]);
    settle();
    checks++;
    if (act_q.size() != 1 || act_q[0][23:0] !== 24'h004011 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_before: got writes=%0d busy=%b expected 1 write 004011 busy=1",
               act_q.size(), busy);
    end
    do_reset(1'b1);
    checks++;
    if ({mem_addr, mem_data, mem_we, busy, done, error, byte_count} !== 44'h0) begin
      errors++;
      $display("FAIL midreset_values: got addr=%h data=%h we=%b busy=%b done=%b err=%b cnt=%h expected all zero",
               mem_addr, mem_data, mem_we, busy, done, error, byte_count);
    end
    send_record(16'h0050, 2, 1'b1, 1'b1);
    send_record(16'h0000, 0, 1'b1, 1'b0);
    settle();
    checks++;
    if (act_q.size() != 2 || exp_q.size() != 2) begin
      errors++;
      $display("FAIL midreset_fresh_count: got %0d expected 2", act_q.size());
    end else begin
      foreach (act_q[i]) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL midreset_fresh[%0d]: got %h expected %h", i, act_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if ({done, error, byte_count} !== {2'b10, 16'd2}) begin
      errors++;
      $display("FAIL midreset_status: got done=%b err=%b cnt=%0d expected 1 0 2", done, error, byte_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s5[] = '{8'hA5, 8'h00, 8'h20, 8'h02, 8'h01, 8'h02, 8'hDB};
    do_reset(1'b0);
    foreach (s5[i]) send(s5[i]);
    settle();
    checks++;
    if (act_q.size() != 2 || exp_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 2", act_q.size());
    end else begin
      checks++;
      if (act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1] ||
          act_q[1][55:24] !== act_q[0][55:24] + 32'd1 ||
          {act_q[0][23:0], act_q[1][23:0]} !== 48'h002001_002102) begin
        errors++;
        $display("FAIL b2b_wr: got %h %h expected %h %h", act_q[0], act_q[1], exp_q[0], exp_q[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset(1'b0);
      for (int k = 0; k < 6; k++) begin
        logic [15:0] a;
        logic [7:0]  junk;
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
          junk = 8'($urandom);
          if (junk == HDR) junk = 8'h00;
          send(junk);
        end
        a = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
        send_record(a, int'($urandom_range(1, 5)), ($urandom_range(0, 9) != 0), 1'b1);
      end
      send_record(16'($urandom), 0, 1'b1, 1'b1);
      settle();
      checks++;
      if (act_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d expected %0d", r, act_q.size(), exp_q.size());
      end else begin
        foreach (act_q[i]) begin
          checks++;
          if (act_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand%0d_wr[%0d]: got %h expected %h", r, i, act_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if ({busy, done, error, byte_count} !==
          {(rec.size() != 0 && m_term == 0), (m_term == 1), (m_term == 2), m_cnt}) begin
        errors++;
        $display("FAIL rand%0d_status: got busy=%b done=%b err=%b cnt=%0d expected busy=%0d term=%0d cnt=%0d",
                 r, busy, done, error, byte_count, (rec.size() != 0 && m_term == 0), m_term, m_cnt);
      end
    end
  endtask

  initial begin
    Reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    test_reset();
    test_basic_and_done();
    test_ignore_leading();
    test_wrap_error();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
